// File: rtl/fetch_align_ctrl_pkg.sv
// Shared IF<->prefetch control types and constants for the fetch alignment controller.
package c_ext_defs;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic instr_req;
    logic access_misalign;
    logic is_comp;
    logic clear;
  } type_if2pref_ctrl_s;

  typedef struct packed {
    logic ack;
  } type_pref2if_ctrl_s;

  typedef struct packed {
    logic [31:0] instr;
  } type_pref2if_data_s;

  typedef enum logic [1:0] {
    S_FLUSH = 2'd0,
    S_REQ   = 2'd1,
    S_ACK   = 2'd2
  } type_fetch_align_state_e;

endpackage

// File: rtl/fetch_align_ctrl_if.sv
// Fetch-to-prefetch control channel: request/clear outward, ack and instruction back.
interface fetch_align_ctrl_if;
  import c_ext_defs::*;

  type_if2pref_ctrl_s ctrl;
  type_pref2if_ctrl_s rsp;
  type_pref2if_data_s data;

  modport master (output ctrl, input rsp, input data);
  modport slave  (input ctrl, output rsp, output data);

endinterface

// File: rtl/fetch_align_ctrl_comp_detect.sv
// Classifies a halfword as a compressed (16-bit) instruction; shared with decode.
module fetch_align_ctrl_comp_detect (
  input  logic [1:0] low_bits,
  output logic       is_comp
);

  assign is_comp = (low_bits != 2'b11);

endmodule

// File: rtl/fetch_align_ctrl.sv
// Fetch-side initiator: tracks the halfword PC, requests instructions from prefetch,
// and presents the aligned instruction to decode; redirects flush and reload the PC.
module fetch_align_ctrl
  import c_ext_defs::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0]      NOP      = NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             stall_i,
  input  logic             peek_valid_i,
  input  logic [15:0]      peek_hw_i,
  fetch_align_ctrl_if.master pref,
  output logic [31:0]      if_instr_o,
  output logic [XLEN-1:0]  if_pc_o,
  output logic             if_is_comp_o,
  output logic             if_valid_o
);

  type_fetch_align_state_e state_q, state_d;
  type_if2pref_ctrl_s      ctrl;
  logic [XLEN-1:0]         pc_q;
  logic                    comp_q;
  logic                    peek_comp;
  logic                    consume;
  logic                    issue;
  logic                    ack_take;

  fetch_align_ctrl_comp_detect u_comp_detect (
    .low_bits (peek_hw_i[1:0]),
    .is_comp  (peek_comp)
  );

  assign consume  = if_valid_o & ~stall_i;
  // Issue only when the output register will be free to take the result.
  assign issue    = (state_q == S_REQ) & peek_valid_i & (~if_valid_o | ~stall_i);
  assign ack_take = (state_q == S_ACK) & pref.rsp.ack;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    if (rst_n) begin
      unique case (state_q)
        S_FLUSH: begin
          ctrl.clear = 1'b1;
          state_d    = S_REQ;
        end
        S_REQ: begin
          if (issue) begin
            ctrl.instr_req       = 1'b1;
            ctrl.access_misalign = pc_q[1];
            ctrl.is_comp         = peek_comp;
            state_d              = S_ACK;
          end
        end
        S_ACK: begin
          ctrl.instr_req       = 1'b1;
          ctrl.access_misalign = pc_q[1];
          ctrl.is_comp         = comp_q;
          if (pref.rsp.ack) state_d = S_REQ;
        end
        default: state_d = S_FLUSH;
      endcase
      if (redirect_i) state_d = S_FLUSH;
    end
  end

  assign pref.ctrl = ctrl;

  // NOTE: reset is synchronous, so it lives inside the clocked block; state uses <= only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FLUSH;
      pc_q         <= RESET_PC;
      comp_q       <= 1'b0;
      if_valid_o   <= 1'b0;
      if_instr_o   <= NOP;
      if_pc_o      <= RESET_PC;
      if_is_comp_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (redirect_i) begin
        // A coinciding ack is dropped: the target PC wins and nothing is loaded.
        pc_q       <= redirect_pc_i & ~XLEN'(1);
        if_valid_o <= 1'b0;
        if_instr_o <= NOP;
      end else begin
        if (issue) comp_q <= peek_comp;
        if (ack_take) begin
          if_instr_o   <= comp_q ? {16'b0, pref.data.instr[15:0]} : pref.data.instr;
          if_pc_o      <= pc_q;
          if_is_comp_o <= comp_q;
          if_valid_o   <= 1'b1;
          pc_q         <= pc_q + (comp_q ? XLEN'(2) : XLEN'(4));
        end else if (consume) begin
          if_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Directed bench for fetch_align_ctrl with a scoreboard of expected decode outputs.
module tb_fetch_align_ctrl;
  import c_ext_defs::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOPV   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        peek_valid;
  logic [15:0] peek_hw;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_is_comp;
  logic        if_valid;

  fetch_align_ctrl_if pref_if ();

  fetch_align_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .stall_i       (stall),
    .peek_valid_i  (peek_valid),
    .peek_hw_i     (peek_hw),
    .pref          (pref_if.master),
    .if_instr_o    (if_instr),
    .if_pc_o       (if_pc),
    .if_is_comp_o  (if_is_comp),
    .if_valid_o    (if_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_e;
  logic [31:0] model_pc;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from S_REQ: issue, optional wait, ack, then scoreboard compare.
  task automatic do_fetch(input logic [15:0] hw, input logic [31:0] raw, input int delay);
    logic c;
    exp_t e;
    c          = (hw[1:0] != 2'b11);
    peek_valid = 1'b1;
    peek_hw    = hw;
    #1;
    check("issue_req",   {31'b0, pref_if.ctrl.instr_req},       32'd1);
    check("issue_mis",   {31'b0, pref_if.ctrl.access_misalign}, {31'b0, model_pc[1]});
    check("issue_comp",  {31'b0, pref_if.ctrl.is_comp},         {31'b0, c});
    check("issue_clear", {31'b0, pref_if.ctrl.clear},           32'd0);
    cyc();
    // Flip the peeked class to prove is_comp_o is held from the latched value.
    peek_hw = {hw[15:2], c ? 2'b11 : 2'b00};
    #1;
    check("ack_req_held",  {31'b0, pref_if.ctrl.instr_req},       32'd1);
    check("ack_mis_held",  {31'b0, pref_if.ctrl.access_misalign}, {31'b0, model_pc[1]});
    check("ack_comp_held", {31'b0, pref_if.ctrl.is_comp},         {31'b0, c});
    check("ack_consumed",  {31'b0, if_valid},                     32'd0);
    for (int i = 0; i < delay; i++) begin
      cyc();
      check("wait_req", {31'b0, pref_if.ctrl.instr_req}, 32'd1);
    end
    pref_if.rsp.ack    = 1'b1;
    pref_if.data.instr = raw;
    sb.push_back('{instr: c ? {16'b0, raw[15:0]} : raw, pc: model_pc, comp: c});
    model_pc = model_pc + (c ? 32'd2 : 32'd4);
    cyc();
    pref_if.rsp.ack = 1'b0;
    peek_valid      = 1'b0;
    e      = sb.pop_front();
    last_e = e;
    check("out_valid", {31'b0, if_valid},   32'd1);
    check("out_instr", if_instr,            e.instr);
    check("out_pc",    if_pc,               e.pc);
    check("out_comp",  {31'b0, if_is_comp}, {31'b0, e.comp});
  endtask

  initial begin
    rst_n              = 1'b0;
    redirect           = 1'b0;
    redirect_pc        = '0;
    stall              = 1'b0;
    peek_valid         = 1'b0;
    peek_hw            = '0;
    pref_if.rsp.ack    = 1'b0;
    pref_if.data.instr = '0;
    model_pc           = RST_PC;

    // Reset
    #1;
    check("rst_cycle_req",   {31'b0, pref_if.ctrl.instr_req}, 32'd0);
    check("rst_cycle_clear", {31'b0, pref_if.ctrl.clear},     32'd0);
    cyc();
    cyc();
    check("rst_valid", {31'b0, if_valid},   32'd0);
    check("rst_instr", if_instr,            NOPV);
    check("rst_pc",    if_pc,               RST_PC);
    check("rst_comp",  {31'b0, if_is_comp}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("flush_clear", {31'b0, pref_if.ctrl.clear},     32'd1);
    check("flush_req",   {31'b0, pref_if.ctrl.instr_req}, 32'd0);
    cyc();

    // Compressed, misaligned 32-bit, compressed with junk upper half
    do_fetch(16'h4501, 32'h0000_4501, 0);
    do_fetch(16'h0513, 32'h00A0_0513, 0);
    do_fetch(16'h4501, 32'hDEAD_4501, 2);

    // Stall holds outputs and blocks issue
    stall      = 1'b1;
    peek_valid = 1'b1;
    peek_hw    = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_req",   {31'b0, pref_if.ctrl.instr_req}, 32'd0);
      check("stall_valid", {31'b0, if_valid},               32'd1);
      check("stall_instr", if_instr,                        last_e.instr);
      check("stall_pc",    if_pc,                           last_e.pc);
      check("stall_comp",  {31'b0, if_is_comp},             {31'b0, last_e.comp});
      cyc();
    end
    stall = 1'b0;
    do_fetch(16'h0001, 32'h1234_0001, 1);

    // No peek data: nothing issues, output drains
    peek_valid = 1'b0;
    #1;
    check("nopeek_req", {31'b0, pref_if.ctrl.instr_req}, 32'd0);
    cyc();
    check("drain_valid", {31'b0, if_valid}, 32'd0);

    // Redirect coinciding with ack
    peek_valid = 1'b1;
    peek_hw    = 16'h0513;
    #1;
    check("pre_redir_req", {31'b0, pref_if.ctrl.instr_req}, 32'd1);
    cyc();
    redirect           = 1'b1;
    redirect_pc        = 32'h8000_1001;
    pref_if.rsp.ack    = 1'b1;
    pref_if.data.instr = 32'hFFFF_FFFF;
    cyc();
    redirect        = 1'b0;
    pref_if.rsp.ack = 1'b0;
    #1;
    check("redir_valid", {31'b0, if_valid},               32'd0);
    check("redir_instr", if_instr,                        NOPV);
    check("redir_clear", {31'b0, pref_if.ctrl.clear},     32'd1);
    check("redir_req",   {31'b0, pref_if.ctrl.instr_req}, 32'd0);
    model_pc = 32'h8000_1000;
    cyc();
    do_fetch(16'h0513, 32'h0041_0513, 0);

    // Redirect while flushing restarts the flush; then PC wrap
    peek_valid  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h8000_2000;
    cyc();
    check("flush1_clear", {31'b0, pref_if.ctrl.clear}, 32'd1);
    redirect_pc = 32'hFFFF_FFFF;
    cyc();
    redirect = 1'b0;
    #1;
    check("flush2_clear", {31'b0, pref_if.ctrl.clear}, 32'd1);
    model_pc = 32'hFFFF_FFFE;
    cyc();
    do_fetch(16'h4501, 32'h0000_4501, 0);
    do_fetch(16'h0513, 32'h0000_0513, 1);

    // Reset during S_ACK; the ack under reset is ignored
    peek_valid = 1'b1;
    peek_hw    = 16'h4501;
    #1;
    cyc();
    rst_n              = 1'b0;
    pref_if.rsp.ack    = 1'b1;
    pref_if.data.instr = 32'h0000_4501;
    #1;
    check("rst2_cycle_req",  {31'b0, pref_if.ctrl.instr_req},       32'd0);
    check("rst2_cycle_mis",  {31'b0, pref_if.ctrl.access_misalign}, 32'd0);
    check("rst2_cycle_comp", {31'b0, pref_if.ctrl.is_comp},         32'd0);
    cyc();
    rst_n           = 1'b1;
    pref_if.rsp.ack = 1'b0;
    #1;
    check("rst2_valid", {31'b0, if_valid},               32'd0);
    check("rst2_instr", if_instr,                        NOPV);
    check("rst2_pc",    if_pc,                           RST_PC);
    check("rst2_comp",  {31'b0, if_is_comp},             32'd0);
    check("rst2_clear", {31'b0, pref_if.ctrl.clear},     32'd1);
    check("rst2_req",   {31'b0, pref_if.ctrl.instr_req}, 32'd0);
    model_pc = RST_PC;
    cyc();
    do_fetch(16'h0513, 32'hCAFE_0513, 0);

    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
